ifq: RTL and testbench
======================

// Module: ifq
// PURPOSE
//  Instruction fetch queue between the fetch stage and the decode stage.
//  Accepts {pc, ins} pairs from fetch over a valid/ready handshake and buffers up to DEPTH entries.
//  Presents the oldest entry to decode over a second valid/ready handshake.
//  Decouples decode stalls from fetch; i_flush discards every buffered entry on a redirect.
// PARAMETERS
//  DEPTH      4    entries; power of two, >= 2
//  CPU_WIDTH  64   pc width, equal to `CPU_WIDTH
//  INS_WIDTH  32   instruction width, equal to `INS_WIDTH
// PORTS
//  i_clk         in   1          clock, all state updates on rising edge
//  i_rst         in   1          synchronous reset, active-high
//  i_pre_valid   in   1          fetch has a valid {pc,ins}
//  o_pre_ready   out  1          queue can accept an entry this cycle
//  i_pre_pc      in   CPU_WIDTH  pc of the incoming instruction
//  i_pre_ins     in   INS_WIDTH  incoming instruction word
//  o_post_valid  out  1          head entry valid for decode
//  i_post_ready  in   1          decode consumes the head entry this cycle
//  o_post_pc     out  CPU_WIDTH  head pc
//  o_post_ins    out  INS_WIDTH  head instruction
//  i_flush       in   1          discard all entries (branch/exception redirect)
//  o_count       out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
// BEHAVIOUR
//  - One clock, i_clk. Reset is synchronous and active-high (i_rst).
//  - Reset: wr_ptr=rd_ptr=0, count=0. Outputs: o_post_valid=0, o_pre_ready=1, o_count=0, o_post_pc=0, o_post_ins=0.
//    The storage array has no reset.
//  - push = i_pre_valid & o_pre_ready & !i_flush.
//  - pop = o_post_valid & i_post_ready & !i_flush.
//  - o_pre_ready = (count != DEPTH). It must not depend combinationally on i_post_ready or i_flush.
//  - o_post_valid = (count != 0). Head data is read combinationally from the storage array (first-word fall-through).
//  - Latency: an entry pushed in cycle N is visible on o_post_* in cycle N+1. There is no same-cycle bypass.
//  - o_post_pc and o_post_ins are forced to 0 while count==0.
//  - Holding rule: the head stays stable while o_post_valid & !i_post_ready (no flush).
//  - Push: store {pc,ins} at wr_ptr, then wr_ptr+1 mod DEPTH.
//  - Pop: rd_ptr+1 mod DEPTH.
//  - Count update:
//    - push & !pop: count+1
//    - pop & !push: count-1
//    - push & pop: count unchanged, including at count==DEPTH-1 and count==1
//  - Pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is held in a separate counter, so full and empty are never ambiguous.
//  - Full (count==DEPTH) with a pop in the same cycle: o_pre_ready stays 0 that cycle. The next cycle has count DEPTH-1 and ready=1.
//  - Flush: next cycle count=0 and wr_ptr=rd_ptr=0. A concurrent push and a concurrent pop are both ignored.
//    In the flush cycle itself, o_post_valid and o_post_* still reflect the pre-flush head; decode must qualify them with !i_flush.
//  - Flush and reset asserted together: reset wins; the result is identical.
//  - Reset mid-operation: all entries are dropped, and outputs return to reset values on the next edge.
//  - Assertions:
//    - never push when count==DEPTH
//    - never pop when count==0
//    - count == (wr_ptr - rd_ptr) mod DEPTH, or DEPTH when full
// STRUCTURE
//  - Widths come from the existing `CPU_WIDTH / `INS_WIDTH defines.
//  - Shared package ifq_pkg:
//    - typedef struct packed {logic [`CPU_WIDTH-1:0] pc; logic [`INS_WIDTH-1:0] ins;} ifq_entry_t
//    - localparam IFQ_DEPTH_DEFAULT = 4
//  - Sub-module ifq_mem: DEPTH x ifq_entry_t register array, one synchronous write port and one asynchronous read port, no reset.
//  - Pointers and count are built from stl_reg instances with a write-enable.
// TESTING
//  1. Reset then idle -> o_post_valid=0, o_pre_ready=1, o_count=0, o_post_pc=0.
//  2. Push pc=0x80000000 ins=0x00000413, i_post_ready=0 -> next cycle o_post_valid=1, o_post_pc=0x80000000, o_post_ins=0x00000413, o_count=1.
//     Hold 3 cycles -> values stable.
//  3. Fill: push pcs 0x80000000..0x8000000C with i_post_ready=0 -> o_count=4, o_pre_ready=0.
//     A 5th push attempt is not accepted.
//     Pop 4 -> pcs emerge in order, then o_post_valid=0.
//  4. Steady stream at count=2 with push&pop every cycle for 20 cycles -> o_count stays 2.
//     Pointers wrap 5 times; order is preserved, each pc = previous pc + 4.
//  5. count=3, then i_flush=1 with simultaneous push of pc=0x80000100 -> next cycle o_count=0, o_post_valid=0.
//     A subsequent push of 0x80000200 appears at the head one cycle later.
//  6. Random valid/ready at 50% each over 2000 cycles against a scoreboard queue -> no loss, no duplication, in-order delivery.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types for the instruction fetch queue: the {pc, ins} entry and the default depth.
// Widths follow the core-wide CPU_WIDTH / INS_WIDTH defines.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif
`ifndef INS_WIDTH
`define INS_WIDTH 32
`endif

package ifq_pkg;

    typedef struct packed {
        logic [`CPU_WIDTH-1:0] pc;
        logic [`INS_WIDTH-1:0] ins;
    } ifq_entry_t;

    localparam int IFQ_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/ifq_mem.sv
// Entry storage for the fetch queue: one synchronous write port, one asynchronous read port.
// Latency: a write is visible on the read port the cycle after it is clocked in.
// Backpressure: none; the caller only writes when a slot is free. No reset on the array.
module ifq_mem
    import ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     wen,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  ifq_entry_t               wdat,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output ifq_entry_t               rdat
);

    ifq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdat;
        end
    end

    assign rdat = mem[raddr];

endmodule

// File: rtl/stl_reg.sv
// Generic register with synchronous active-high reset and write enable.
// Latency: one cycle from din to dout.
// Backpressure: none; holds its value while wen is low.
module stl_reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/ifq.sv
// Instruction fetch queue between fetch and decode, first-word fall-through.
// Latency: an entry pushed in cycle N is at the head in cycle N+1; no same-cycle bypass.
// Backpressure: o_pre_ready drops only when full (count-based, independent of pop or flush).
module ifq
    import ifq_pkg::*;
#(
    parameter int DEPTH     = IFQ_DEPTH_DEFAULT,
    parameter int CPU_WIDTH = `CPU_WIDTH,
    parameter int INS_WIDTH = `INS_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_pre_valid,
    output logic                   o_pre_ready,
    input  logic [CPU_WIDTH-1:0]   i_pre_pc,
    input  logic [INS_WIDTH-1:0]   i_pre_ins,
    output logic                   o_post_valid,
    input  logic                   i_post_ready,
    output logic [CPU_WIDTH-1:0]   o_post_pc,
    output logic [INS_WIDTH-1:0]   o_post_ins,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int             PW   = $clog2(DEPTH);
    localparam int             CW   = PW + 1;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          push;
    logic          pop;
    logic          wr_ptr_wen;
    logic          rd_ptr_wen;
    logic          count_wen;
    ifq_entry_t    wr_entry;
    ifq_entry_t    head;

    assign o_pre_ready  = (count != FULL);
    assign o_post_valid = (count != '0);

    assign push = i_pre_valid & o_pre_ready & ~i_flush;
    assign pop  = o_post_valid & i_post_ready & ~i_flush;

    // Flush rewinds both pointers to zero so the occupancy invariant restarts cleanly.
    assign wr_ptr_wen = push | i_flush;
    assign rd_ptr_wen = pop | i_flush;
    assign wr_ptr_nxt = i_flush ? '0 : wr_ptr + PW'(1);
    assign rd_ptr_nxt = i_flush ? '0 : rd_ptr + PW'(1);

    assign count_wen = (push ^ pop) | i_flush;
    assign count_nxt = i_flush ? '0 : (push ? count + CW'(1) : count - CW'(1));

    stl_reg #(.WIDTH(PW)) u_wr_ptr (
        .clk  (i_clk),
        .rst  (i_rst),
        .wen  (wr_ptr_wen),
        .din  (wr_ptr_nxt),
        .dout (wr_ptr)
    );

    stl_reg #(.WIDTH(PW)) u_rd_ptr (
        .clk  (i_clk),
        .rst  (i_rst),
        .wen  (rd_ptr_wen),
        .din  (rd_ptr_nxt),
        .dout (rd_ptr)
    );

    stl_reg #(.WIDTH(CW)) u_count (
        .clk  (i_clk),
        .rst  (i_rst),
        .wen  (count_wen),
        .din  (count_nxt),
        .dout (count)
    );

    assign wr_entry.pc  = i_pre_pc;
    assign wr_entry.ins = i_pre_ins;

    ifq_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (i_clk),
        .wen   (push),
        .waddr (wr_ptr),
        .wdat  (wr_entry),
        .raddr (rd_ptr),
        .rdat  (head)
    );

    // Stale array contents never leak out while empty.
    assign o_post_pc  = o_post_valid ? head.pc  : '0;
    assign o_post_ins = o_post_valid ? head.ins : '0;
    assign o_count    = count;

    a_no_push_full: assert property (@(posedge i_clk) disable iff (i_rst)
        !(push && (count == FULL)));

    a_no_pop_empty: assert property (@(posedge i_clk) disable iff (i_rst)
        !(pop && (count == '0)));

    a_count_ptrs: assert property (@(posedge i_clk) disable iff (i_rst)
        (count <= FULL) && (count[PW-1:0] == PW'(wr_ptr - rd_ptr)));

endmodule

// File: tb/tb_ifq.sv
// Self-checking bench for ifq: directed scenarios plus a random valid/ready run against a scoreboard queue.
module tb_ifq;
    import ifq_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        i_rst;
    logic        i_pre_valid;
    logic        o_pre_ready;
    logic [63:0] i_pre_pc;
    logic [31:0] i_pre_ins;
    logic        o_post_valid;
    logic        i_post_ready;
    logic [63:0] o_post_pc;
    logic [31:0] o_post_ins;
    logic        i_flush;
    logic [2:0]  o_count;

    int n_tests = 0;
    int n_fail  = 0;
    ifq_entry_t sb[$];

    ifq #(.DEPTH(DEPTH), .CPU_WIDTH(64), .INS_WIDTH(32)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_pre_valid  (i_pre_valid),
        .o_pre_ready  (o_pre_ready),
        .i_pre_pc     (i_pre_pc),
        .i_pre_ins    (i_pre_ins),
        .o_post_valid (o_post_valid),
        .i_post_ready (i_post_ready),
        .o_post_pc    (o_post_pc),
        .o_post_ins   (o_post_ins),
        .i_flush      (i_flush),
        .o_count      (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of inputs and updates the scoreboard with what the queue must accept.
    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl);
        ifq_entry_t e;
        i_pre_valid  = v;
        i_pre_pc     = pc;
        i_pre_ins    = ins;
        i_post_ready = rdy;
        i_flush      = fl;
        if (fl) begin
            sb.delete();
        end else begin
            logic can_push;
            can_push = v && (sb.size() < DEPTH);
            if (rdy && (sb.size() != 0)) void'(sb.pop_front());
            if (can_push) begin
                e.pc  = pc;
                e.ins = ins;
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle();
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        idle();
        tick();
        tick();
        i_rst = 1'b0;
        tick();
        n_tests++; if (o_post_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_post_valid); end
        n_tests++; if (o_pre_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_pre_ready); end
        n_tests++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", o_count); end
        n_tests++; if (o_post_pc !== 64'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", o_post_pc); end
        n_tests++; if (o_post_ins !== 32'h0) begin n_fail++; $display("FAIL reset_ins: got %h want 0", o_post_ins); end
    endtask

    task automatic test_single();
        drive(1'b1, 64'h80000000, 32'h00000413, 1'b0, 1'b0);
        n_tests++; if (o_post_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b want 0", o_post_valid); end
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (o_post_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid[%0d]: got %b want 1", i, o_post_valid); end
            n_tests++; if (o_post_pc !== 64'h80000000) begin n_fail++; $display("FAIL single_pc[%0d]: got %h want 80000000", i, o_post_pc); end
            n_tests++; if (o_post_ins !== 32'h00000413) begin n_fail++; $display("FAIL single_ins[%0d]: got %h want 00000413", i, o_post_ins); end
            n_tests++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL single_count[%0d]: got %0d want 1", i, o_count); end
            tick();
        end
        drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        tick();
        idle();
        n_tests++; if (o_post_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b want 0", o_post_valid); end
        n_tests++; if (o_post_ins !== 32'h0) begin n_fail++; $display("FAIL single_ins_zero: got %h want 0", o_post_ins); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h80000000 + 64'(4 * i), 32'(i + 1), 1'b0, 1'b0);
            tick();
        end
        n_tests++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", o_count); end
        n_tests++; if (o_pre_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b want 0", o_pre_ready); end
        drive(1'b1, 64'h80000010, 32'h5, 1'b0, 1'b0);
        tick();
        n_tests++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL fill_5th_rejected: got %0d want 4", o_count); end
        // Pop while full with a push pending: ready must stay low this cycle.
        n_tests++; if (o_post_pc !== 64'h80000000) begin n_fail++; $display("FAIL fill_pop0: got %h want 80000000", o_post_pc); end
        drive(1'b1, 64'h80000010, 32'h5, 1'b1, 1'b0);
        n_tests++; if (o_pre_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_ready: got %b want 0", o_pre_ready); end
        tick();
        idle();
        n_tests++; if (o_count !== 3'd3) begin n_fail++; $display("FAIL full_pop_count: got %0d want 3", o_count); end
        n_tests++; if (o_pre_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_ready_next: got %b want 1", o_pre_ready); end
        for (int i = 1; i < 4; i++) begin
            n_tests++; if (o_post_pc !== sb[0].pc || o_post_pc !== 64'h80000000 + 64'(4 * i))
                begin n_fail++; $display("FAIL fill_order[%0d]: got %h want %h", i, o_post_pc, 64'h80000000 + 64'(4 * i)); end
            n_tests++; if (o_post_ins !== sb[0].ins) begin n_fail++; $display("FAIL fill_ins[%0d]: got %h want %h", i, o_post_ins, sb[0].ins); end
            drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
            tick();
        end
        idle();
        n_tests++; if (o_post_valid !== 1'b0) begin n_fail++; $display("FAIL fill_empty: got %b want 0", o_post_valid); end
    endtask

    task automatic test_stream();
        logic [63:0] nxt;
        logic [63:0] prev;
        nxt = 64'h80001000;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, nxt, 32'(nxt), 1'b0, 1'b0);
            nxt += 64'd4;
            tick();
        end
        prev = 64'h80001000 - 64'd4;
        for (int i = 0; i < 20; i++) begin
            n_tests++; if (o_post_pc !== sb[0].pc || o_post_pc !== prev + 64'd4)
                begin n_fail++; $display("FAIL stream_order[%0d]: got %h want %h", i, o_post_pc, prev + 64'd4); end
            prev = o_post_pc;
            drive(1'b1, nxt, 32'(nxt), 1'b1, 1'b0);
            nxt += 64'd4;
            tick();
            n_tests++; if (o_count !== 3'd2) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d want 2", i, o_count); end
        end
        // Push and pop together at count 1 and at count DEPTH-1 leave count unchanged.
        drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b1, nxt, 32'(nxt), 1'b1, 1'b0);
        nxt += 64'd4;
        tick();
        n_tests++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL pushpop_at1: got %0d want 1", o_count); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, nxt, 32'(nxt), 1'b0, 1'b0);
            nxt += 64'd4;
            tick();
        end
        n_tests++; if (o_post_pc !== sb[0].pc) begin n_fail++; $display("FAIL pushpop_at3_head: got %h want %h", o_post_pc, sb[0].pc); end
        drive(1'b1, nxt, 32'(nxt), 1'b1, 1'b0);
        tick();
        n_tests++; if (o_count !== 3'd3) begin n_fail++; $display("FAIL pushpop_at3: got %0d want 3", o_count); end
        while (sb.size() != 0) begin
            n_tests++; if (o_post_pc !== sb[0].pc) begin n_fail++; $display("FAIL stream_drain: got %h want %h", o_post_pc, sb[0].pc); end
            drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
            tick();
        end
        idle();
    endtask

    task automatic test_flush();
        logic [63:0] head_pc;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h80000040 + 64'(4 * i), 32'(i), 1'b0, 1'b0);
            tick();
        end
        head_pc = sb[0].pc;
        drive(1'b1, 64'h80000100, 32'h100, 1'b1, 1'b1);
        n_tests++; if (o_post_valid !== 1'b1 || o_post_pc !== head_pc)
            begin n_fail++; $display("FAIL flush_cycle_head: got %b/%h want 1/%h", o_post_valid, o_post_pc, head_pc); end
        tick();
        idle();
        n_tests++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", o_count); end
        n_tests++; if (o_post_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", o_post_valid); end
        drive(1'b1, 64'h80000200, 32'h200, 1'b0, 1'b0);
        tick();
        idle();
        n_tests++; if (o_post_valid !== 1'b1 || o_post_pc !== 64'h80000200)
            begin n_fail++; $display("FAIL flush_refill: got %b/%h want 1/80000200", o_post_valid, o_post_pc); end
        n_tests++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL flush_refill_count: got %0d want 1", o_count); end
        // Reset together with flush and a push: everything dropped.
        drive(1'b1, 64'h80000300, 32'h300, 1'b0, 1'b0);
        tick();
        i_rst = 1'b1;
        drive(1'b1, 64'h80000400, 32'h400, 1'b1, 1'b1);
        tick();
        i_rst = 1'b0;
        idle();
        n_tests++; if (o_count !== 3'd0 || o_post_valid !== 1'b0 || o_pre_ready !== 1'b1 || o_post_pc !== 64'h0)
            begin n_fail++; $display("FAIL rst_flush: got cnt=%0d v=%b r=%b pc=%h want 0/0/1/0", o_count, o_post_valid, o_pre_ready, o_post_pc); end
    endtask

    task automatic test_random();
        logic        v;
        logic        r;
        logic [63:0] pc;
        int          guard;
        pc = 64'h80010000;
        for (int i = 0; i < 2000; i++) begin
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            n_tests++; if (o_count !== 3'(sb.size())) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, o_count, sb.size()); end
            if (r && sb.size() != 0) begin
                n_tests++; if (o_post_pc !== sb[0].pc || o_post_ins !== sb[0].ins)
                    begin n_fail++; $display("FAIL rand_data[%0d]: got %h/%h want %h/%h", i, o_post_pc, o_post_ins, sb[0].pc, sb[0].ins); end
            end
            drive(v, pc, $urandom, r, 1'b0);
            if (v) pc += 64'd4;
            tick();
        end
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            n_tests++; if (o_post_pc !== sb[0].pc) begin n_fail++; $display("FAIL rand_drain: got %h want %h", o_post_pc, sb[0].pc); end
            drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
            tick();
            guard++;
        end
        idle();
        n_tests++; if (o_post_valid !== 1'b0 || o_count !== 3'd0)
            begin n_fail++; $display("FAIL rand_final_empty: got %b/%0d want 0/0", o_post_valid, o_count); end
    endtask

    initial begin
        i_rst = 1'b1;
        idle();
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
